// File: rtl/lod_normalizer.sv
// Sequential leading-one normalizer: shifts a captured operand left one bit per
// cycle until its MSB is set, reporting the shift count and an all-zero flag.
module lod_normalizer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    input  logic             ack,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] data_out,
    output logic [CNT_W-1:0] shift_cnt,
    output logic             zero,
    output logic [1:0]       state
);

    // Handshake: a job is accepted on any edge where start && ready; the result
    // is offered while done=1 and released on the edge where ack && done.
    // start outside IDLE and ack outside DONE have no effect.
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q;
    logic [WIDTH-1:0] data_q;
    logic [CNT_W-1:0] cnt_q;
    logic             zero_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        data_q  <= data_in;
                        cnt_q   <= '0;
                        zero_q  <= 1'b0;
                        state_q <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A nonzero word reaches MSB=1 within WIDTH-1 shifts, so cnt_q cannot wrap.
                    if (data_q == '0) begin
                        zero_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (data_q[WIDTH-1]) begin
                        state_q <= DONE;
                    end else begin
                        data_q <= data_q << 1;
                        cnt_q  <= cnt_q + CNT_ONE;
                    end
                end
                DONE: begin
                    if (ack) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_q == IDLE);
    assign busy      = (state_q == SHIFT);
    assign done      = (state_q == DONE);
    assign data_out  = data_q;
    assign shift_cnt = cnt_q;
    assign zero      = zero_q;
    assign state     = state_q;

endmodule

// File: tb/tb_lod_normalizer.sv
// Directed bench for lod_normalizer: hand-computed vectors checked with
// immediate assertions after each clock edge.
module tb_lod_normalizer;

    localparam int WIDTH = 16;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic             ack;
    logic             ready;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] data_out;
    logic [CNT_W-1:0] shift_cnt;
    logic             zero;
    logic [1:0]       state;

    int compared;
    int mismatched;

    lod_normalizer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .data_in  (data_in),
        .ack      (ack),
        .ready    (ready),
        .busy     (busy),
        .done     (done),
        .data_out (data_out),
        .shift_cnt(shift_cnt),
        .zero     (zero),
        .state    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1ns past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for done, counting edges after the start-sampling edge.
    task automatic wait_done(output int edges);
        edges = 0;
        while (!done && edges < 40) begin
            tick();
            edges++;
        end
    endtask

    task automatic run_job(input string tag, input logic [WIDTH-1:0] operand,
                           input logic [WIDTH-1:0] exp_out, input int exp_cnt,
                           input logic exp_zero, input int exp_lat);
        int edges;
        start   = 1'b1;
        data_in = operand;
        tick();
        start   = 1'b0;
        data_in = '0;
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
        wait_done(edges);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_lat"}, edges, exp_lat);
        check({tag, "_out"}, {16'd0, data_out}, {16'd0, exp_out});
        check({tag, "_cnt"}, {28'd0, shift_cnt}, exp_cnt);
        check({tag, "_zero"}, {31'd0, zero}, {31'd0, exp_zero});
    endtask

    task automatic do_ack(input string tag);
        ack = 1'b1;
        tick();
        ack = 1'b0;
        check({tag, "_ready"}, {31'd0, ready}, 32'd1);
        check({tag, "_done_clr"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int edges;
        compared   = 0;
        mismatched = 0;
        rst     = 1'b1;
        start   = 1'b0;
        ack     = 1'b0;
        data_in = '0;
        tick();
        tick();
        rst = 1'b0;

        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_out", {16'd0, data_out}, 32'd0);
        check("rst_cnt", {28'd0, shift_cnt}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
        check("rst_state", {30'd0, state}, 32'd0);

        run_job("msb", 16'h8000, 16'h8000, 0, 1'b0, 1);
        do_ack("msb");
        run_job("lsb", 16'h0001, 16'h8000, 15, 1'b0, 16);
        do_ack("lsb");
        run_job("zero", 16'h0000, 16'h0000, 0, 1'b1, 1);
        do_ack("zero");
        run_job("mid", 16'h0A30, 16'hA300, 4, 1'b0, 5);
        do_ack("mid");

        // start held high with a different operand throughout SHIFT and DONE
        start   = 1'b1;
        data_in = 16'h0A30;
        tick();
        data_in = 16'h0001;
        wait_done(edges);
        check("hold_done", {31'd0, done}, 32'd1);
        check("hold_lat", edges, 5);
        check("hold_out", {16'd0, data_out}, 32'h0000A300);
        check("hold_cnt", {28'd0, shift_cnt}, 32'd4);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_done", {31'd0, done}, 32'd1);
            check("stall_out", {16'd0, data_out}, 32'h0000A300);
            check("stall_cnt", {28'd0, shift_cnt}, 32'd4);
        end
        // start and ack together in DONE: only ack acts
        ack = 1'b1;
        tick();
        ack   = 1'b0;
        start = 1'b0;
        check("both_ready", {31'd0, ready}, 32'd1);
        check("both_out", {16'd0, data_out}, 32'h0000A300);
        check("both_cnt", {28'd0, shift_cnt}, 32'd4);
        tick();
        check("idle_hold_ready", {31'd0, ready}, 32'd1);
        check("idle_hold_out", {16'd0, data_out}, 32'h0000A300);

        // reset in the middle of a shift sequence
        start   = 1'b1;
        data_in = 16'h0001;
        tick();
        start = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_cnt", {28'd0, shift_cnt}, 32'd6);
        check("pre_rst_out", {16'd0, data_out}, 32'h00000040);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", {31'd0, ready}, 32'd1);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_done", {31'd0, done}, 32'd0);
        check("mid_rst_cnt", {28'd0, shift_cnt}, 32'd0);
        check("mid_rst_out", {16'd0, data_out}, 32'd0);
        run_job("post_rst", 16'h4000, 16'h8000, 1, 1'b0, 2);
        do_ack("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
